// File: rtl/ray_marcher.sv
// ray_marcher: sphere-tracing controller that sits upstream of an SDF evaluator.
// It accepts one ray, issues sample points p = o + t*d over a start/done
// handshake, accumulates t by the returned distance, and reports
// hit / distance / step count.
//
// Optional feature macro: RAY_STEP_SHADE_EN.
//   When defined, ray_shade is a step-based shade latched at DONE.
//   When undefined, ray_shade is the constant 8'hFF.
//
// Ports:
//   clk_in, rst_in                    clock, async active-high reset
//   ray_start                         one-cycle request, sampled in IDLE only
//   ray_o{x,y,z}, ray_d{x,y,z}        ray origin / direction, signed fixed point
//   ray_busy                          high from accepted start through ray_done
//   ray_done                          one-cycle result strobe
//   ray_hit, ray_t, ray_steps         result: hit flag, marched t, SDF evaluations
//   ray_shade                         step-based shade (8'hFF when feature is off)
//   sdf_start                         one-cycle pulse to the SDF evaluator
//   sdf_{x,y,z}                       sample point, held for the whole wait
//   sdf_done, sdf_dist                SDF result strobe and signed distance
module ray_marcher #(
  parameter int BITS      = 32,
  parameter int FIXED     = 16,
  parameter int MAX_STEPS = 64,
  parameter int EPSILON   = 66,
  parameter int MAX_DIST  = 1310720
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   ray_start,
  input  logic signed [BITS-1:0] ray_ox,
  input  logic signed [BITS-1:0] ray_oy,
  input  logic signed [BITS-1:0] ray_oz,
  input  logic signed [BITS-1:0] ray_dx,
  input  logic signed [BITS-1:0] ray_dy,
  input  logic signed [BITS-1:0] ray_dz,
  output logic                   ray_busy,
  output logic                   ray_done,
  output logic                   ray_hit,
  output logic signed [BITS-1:0] ray_t,
  output logic [7:0]             ray_steps,
  output logic [7:0]             ray_shade,
  output logic                   sdf_start,
  output logic signed [BITS-1:0] sdf_x,
  output logic signed [BITS-1:0] sdf_y,
  output logic signed [BITS-1:0] sdf_z,
  input  logic                   sdf_done,
  input  logic signed [BITS-1:0] sdf_dist
);

  localparam int unsigned W  = BITS;
  localparam int unsigned WW = 2 * BITS;
  localparam int unsigned WS = BITS + 1;

  localparam logic signed [W-1:0] EPS_W      = W'(EPSILON);
  localparam logic signed [W-1:0] MAX_DIST_W = W'(MAX_DIST);
  localparam logic signed [W-1:0] T_MAX      = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] T_MIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [7:0]          STEPS_MAX  = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  // o + ((t*d) >>> FIXED): full-width signed product, arithmetic shift, truncate
  function automatic logic signed [W-1:0] fx_point(
    input logic signed [W-1:0] o,
    input logic signed [W-1:0] t,
    input logic signed [W-1:0] d
  );
    logic signed [WW-1:0] prod;
    prod = WW'(t) * WW'(d);
    return o + W'(prod >>> FIXED);
  endfunction

  // Signed add clamped to the representable range
  function automatic logic signed [W-1:0] sat_add(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [WS-1:0] s;
    s = WS'(a) + WS'(b);
    if (s > WS'(T_MAX)) begin
      return T_MAX;
    end else if (s < WS'(T_MIN)) begin
      return T_MIN;
    end else begin
      return W'(s);
    end
  endfunction

`ifdef RAY_STEP_SHADE_EN
  // 255 - min(4*steps, 255), evaluated at 10 bits
  function automatic logic [7:0] step_shade(input logic [7:0] steps);
    logic [9:0] s10;
    s10 = {steps, 2'b00};
    if (s10 > 10'd255) begin
      s10 = 10'd255;
    end
    return 8'(10'd255 - s10);
  endfunction
`endif

  state_t            state_q, state_d;
  logic signed [W-1:0] ox_q, oy_q, oz_q, ox_d, oy_d, oz_d;
  logic signed [W-1:0] dx_q, dy_q, dz_q, dx_d, dy_d, dz_d;
  logic signed [W-1:0] t_q, t_d;
  logic signed [W-1:0] dist_q, dist_d;
  logic [7:0]          steps_q, steps_d;
  logic signed [W-1:0] sdf_x_q, sdf_y_q, sdf_z_q, sdf_x_d, sdf_y_d, sdf_z_d;
  logic                sdf_start_q, sdf_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;
  logic signed [W-1:0] rt_q, rt_d;
  logic [7:0]          rsteps_q, rsteps_d;
`ifdef RAY_STEP_SHADE_EN
  logic [7:0]          shade_q, shade_d;
`endif

  logic                fin_c;
  logic                fin_hit_c;
  logic signed [W-1:0] fin_t_c;
  logic signed [W-1:0] t_sum_c;

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    oz_d        = oz_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    dz_d        = dz_q;
    t_d         = t_q;
    dist_d      = dist_q;
    steps_d     = steps_q;
    sdf_x_d     = sdf_x_q;
    sdf_y_d     = sdf_y_q;
    sdf_z_d     = sdf_z_q;
    sdf_start_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    rt_d        = rt_q;
    rsteps_d    = rsteps_q;
`ifdef RAY_STEP_SHADE_EN
    shade_d     = shade_q;
`endif
    fin_c       = 1'b0;
    fin_hit_c   = 1'b0;
    fin_t_c     = t_q;
    t_sum_c     = sat_add(t_q, dist_q);

    case (state_q)
      S_IDLE: begin
        if (ray_start) begin
          ox_d    = ray_ox;
          oy_d    = ray_oy;
          oz_d    = ray_oz;
          dx_d    = ray_dx;
          dy_d    = ray_dy;
          dz_d    = ray_dz;
          t_d     = '0;
          steps_d = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sdf_x_d     = fx_point(ox_q, t_q, dx_q);
        sdf_y_d     = fx_point(oy_q, t_q, dy_q);
        sdf_z_d     = fx_point(oz_q, t_q, dz_q);
        sdf_start_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (sdf_done) begin
          dist_d  = sdf_dist;
          steps_d = steps_q + 8'd1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (dist_q < EPS_W) begin
          fin_c     = 1'b1;
          fin_hit_c = 1'b1;
        end else if (steps_q == STEPS_MAX) begin
          fin_c = 1'b1;
        end else if (t_sum_c > MAX_DIST_W) begin
          fin_c   = 1'b1;
          fin_t_c = t_sum_c;
          t_d     = t_sum_c;
        end else begin
          t_d     = t_sum_c;
          state_d = S_ISSUE;
        end
        if (fin_c) begin
          done_d   = 1'b1;
          hit_d    = fin_hit_c;
          rt_d     = fin_t_c;
          rsteps_d = steps_q;
`ifdef RAY_STEP_SHADE_EN
          shade_d  = fin_hit_c ? step_shade(steps_q) : 8'h00;
`endif
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      oz_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      t_q         <= '0;
      dist_q      <= '0;
      steps_q     <= '0;
      sdf_x_q     <= '0;
      sdf_y_q     <= '0;
      sdf_z_q     <= '0;
      sdf_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      rt_q        <= '0;
      rsteps_q    <= '0;
`ifdef RAY_STEP_SHADE_EN
      shade_q     <= 8'hFF;
`endif
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      oz_q        <= oz_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dz_q        <= dz_d;
      t_q         <= t_d;
      dist_q      <= dist_d;
      steps_q     <= steps_d;
      sdf_x_q     <= sdf_x_d;
      sdf_y_q     <= sdf_y_d;
      sdf_z_q     <= sdf_z_d;
      sdf_start_q <= sdf_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      rt_q        <= rt_d;
      rsteps_q    <= rsteps_d;
`ifdef RAY_STEP_SHADE_EN
      shade_q     <= shade_d;
`endif
    end
  end

  assign ray_busy  = busy_q;
  assign ray_done  = done_q;
  assign ray_hit   = hit_q;
  assign ray_t     = rt_q;
  assign ray_steps = rsteps_q;
  assign sdf_start = sdf_start_q;
  assign sdf_x     = sdf_x_q;
  assign sdf_y     = sdf_y_q;
  assign sdf_z     = sdf_z_q;
`ifdef RAY_STEP_SHADE_EN
  assign ray_shade = shade_q;
`else
  assign ray_shade = 8'hFF;
`endif

endmodule
